// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-busy freezes,
// plus a sticky memory-wait timeout flag and a saturating bubble counter.
module hazard_unit #(
    parameter int unsigned BR_EXTRA = 1,
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             ctrl_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

    localparam logic [2:0] BrExtra = 3'(BR_EXTRA);
    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [7:0]       wait_q, wait_d;
    logic             timeout_q;
    logic [CNT_W-1:0] bubble_q;
    logic             lu;

    assign lu = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_q      <= wait_d;
            if (mem_busy && (wait_d == MaxWait)) begin
                timeout_q <= 1'b1;
            end
            if (!ctrl_sel && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    // MEMWAIT with mem_busy low evaluates exactly like RUN.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (mem_busy) begin
            state_d     = StMemWait;
            flush_cnt_d = '0;
        end else if (branch_taken) begin
            flush_cnt_d = BrExtra;
            state_d     = (BrExtra != 3'd0) ? StFlush : StRun;
        end else if (state_q == StFlush) begin
            flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
            state_d     = (flush_cnt_q <= 3'd1) ? StRun : StFlush;
        end else begin
            state_d     = StRun;
            flush_cnt_d = '0;
        end
    end

    always_comb begin
        wait_d = '0;
        if (mem_busy) begin
            wait_d = (wait_q < MaxWait) ? wait_q + 8'd1 : wait_q;
        end
    end

    always_comb begin
        ctrl_sel   = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (rst) begin
            ctrl_sel   = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (branch_taken || (state_q == StFlush)) begin
            ctrl_sel   = 1'b0;
            ifid_flush = 1'b1;
        end else if (lu) begin
            ctrl_sel   = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    assign mem_timeout  = timeout_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand-written multi-cycle
// sequences, and random stimulus against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam int BR_EXTRA = 1;
    localparam int MAX_WAIT = 255;
    localparam int CNT_W    = 16;

    // Output vector order: {ctrl_sel, pc_write, ifid_write, ifid_flush, pipe_hold}
    localparam logic [4:0] ORun   = 5'b11100;
    localparam logic [4:0] OStall = 5'b00000;
    localparam logic [4:0] OFlush = 5'b01110;
    localparam logic [4:0] OHold  = 5'b10001;
    localparam logic [4:0] ORst   = 5'b00010;

    logic             clk = 1'b0;
    logic             rst;
    logic             idex_memread;
    logic [4:0]       idex_rt, ifid_rs, ifid_rt;
    logic             branch_taken, mem_busy;
    logic             ctrl_sel, pc_write, ifid_write, ifid_flush, pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] bubble_count;
    logic [4:0]       o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending extra flush cycles, consecutive busy count, sticky flag, bubbles.
    int m_flush, m_wait, m_bub;
    bit m_to;

    hazard_unit #(
        .BR_EXTRA (BR_EXTRA),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .ctrl_sel     (ctrl_sel),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .pipe_hold    (pipe_hold),
        .mem_timeout  (mem_timeout),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    assign o = {ctrl_sel, pc_write, ifid_write, ifid_flush, pipe_hold};

    typedef struct {
        logic       mr;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] irt;
        logic       br;
        logic       mb;
        logic [4:0] exp;
        int         bub;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] irt, input logic br, input logic mb);
        idex_memread = mr;
        idex_rt      = rt;
        ifid_rs      = rs;
        ifid_rt      = irt;
        branch_taken = br;
        mem_busy     = mb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] m_out();
        logic lu;
        lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (mem_busy) return OHold;
        if (branch_taken || m_flush > 0) return OFlush;
        if (lu) return OStall;
        return ORun;
    endfunction

    function automatic void m_step();
        logic [4:0] e;
        e = m_out();
        if (!e[4] && m_bub < (1 << CNT_W) - 1) m_bub++;
        if (mem_busy) begin
            m_flush = 0;
            if (m_wait < MAX_WAIT) m_wait++;
            if (m_wait == MAX_WAIT) m_to = 1'b1;
        end else begin
            m_wait = 0;
            if (branch_taken) m_flush = BR_EXTRA;
            else if (m_flush > 0) m_flush--;
        end
    endfunction

    initial begin
        tbl[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ORun,   0};
        tbl[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, OStall, 0};
        tbl[2]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ORun,   1};
        tbl[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ORun,   1};
        tbl[4]  = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, OStall, 1};
        tbl[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, OFlush, 2};
        tbl[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, OFlush, 3};
        tbl[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ORun,   4};
        tbl[8]  = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, OFlush, 4};
        tbl[9]  = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, OFlush, 5};
        tbl[10] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, OHold,  6};
        tbl[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, OHold,  6};
        tbl[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ORun,   6};
        tbl[13] = '{1'b1, 5'd4, 5'd2, 5'd3, 1'b0, 1'b0, ORun,   6};

        // Reset values
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("reset_outputs", 32'(o), 32'(ORst));
        check("reset_bubble", 32'(bubble_count), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        tick();
        check("reset_edge_no_bubble", 32'(bubble_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].mr, tbl[i].rt, tbl[i].rs, tbl[i].irt, tbl[i].br, tbl[i].mb);
            @(negedge clk);
            check($sformatf("vec%0d_outputs", i), 32'(o), 32'(tbl[i].exp));
            check($sformatf("vec%0d_bubble", i), 32'(bubble_count), 32'(tbl[i].bub));
            check($sformatf("vec%0d_timeout", i), 32'(mem_timeout), 32'd0);
            tick();
        end

        // Back-to-back branches: three flush cycles, then run
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk); check("dbl_br_c1", 32'(o), 32'(OFlush)); tick();
        @(negedge clk); check("dbl_br_c2", 32'(o), 32'(OFlush)); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk); check("dbl_br_c3", 32'(o), 32'(OFlush)); tick();
        @(negedge clk); check("dbl_br_run", 32'(o), 32'(ORun));
        check("dbl_br_bubble", 32'(bubble_count), 32'd9);
        tick();

        // Long busy with branch and load-use asserted: freeze, then timeout on the 255th edge
        drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b1);
        for (int i = 1; i < MAX_WAIT; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i), 32'(o), 32'(OHold));
            tick();
            if (i == 3) check("busy_no_timeout_c3", 32'(mem_timeout), 32'd0);
        end
        check("busy_254_no_timeout", 32'(mem_timeout), 32'd0);
        tick();
        check("busy_255_timeout", 32'(mem_timeout), 32'd1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        check("after_busy_run", 32'(o), 32'(ORun));
        check("busy_bubble", 32'(bubble_count), 32'd9);
        tick();

        // Asynchronous reset in the middle of a flush
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("mid_flush", 32'(o), 32'(OFlush));
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'(o), 32'(ORst));
        check("async_rst_bubble", 32'(bubble_count), 32'd0);
        check("async_rst_timeout", 32'(mem_timeout), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_run", 32'(o), 32'(ORun));
        check("post_rst_bubble", 32'(bubble_count), 32'd0);
        tick();

        // Random stimulus against the model, starting from reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_flush = 0; m_wait = 0; m_bub = 0; m_to = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0));
            @(negedge clk);
            check($sformatf("rnd%0d_outputs", i), 32'(o), 32'(m_out()));
            check($sformatf("rnd%0d_bubble", i), 32'(bubble_count), 32'(m_bub));
            check($sformatf("rnd%0d_timeout", i), 32'(mem_timeout), 32'(m_to));
            @(posedge clk);
            m_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter BR_EXTRA, default 1: extra flush cycles after the cycle in which a taken branch is first seen (0..7).
REQ-002 Parameter MAX_WAIT, default 255: mem_busy cycle count at which timeout is flagged (1..255).
REQ-003 Parameter CNT_W, default 16: width of bubble_count.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 idex_memread  in  1  instruction in ID/EX is a load.
REQ-007 idex_rt  in  5  destination register of the ID/EX load.
REQ-008 ifid_rs  in  5  rs field of the IF/ID instruction.
REQ-009 ifid_rt  in  5  rt field of the IF/ID instruction.
REQ-010 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-011 mem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-012 ctrl_sel  out  1  select to the control bubble mux: 1 = pass control lines, 0 = insert bubble.
REQ-013 pc_write  out  1  PC load enable.
REQ-014 ifid_write  out  1  IF/ID register load enable.
REQ-015 ifid_flush  out  1  clear IF/ID to NOP.
REQ-016 pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
REQ-017 mem_timeout  out  1  sticky flag: mem_busy reached MAX_WAIT consecutive cycles.
REQ-018 bubble_count  out  CNT_W  saturating count of cycles with ctrl_sel = 0 outside reset.

Function
REQ-019 LU = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
REQ-020 FSM states: RUN, MEMWAIT, FLUSH; outputs are combinational from the current state and inputs (Mealy); state and counters are registered.
REQ-021 Event priority in every state: mem_busy > branch_taken > LU.
REQ-022 RUN, no event: ctrl_sel=1, pc_write=1, ifid_write=1, ifid_flush=0, pipe_hold=0; stay in RUN.
REQ-023 RUN with LU: ctrl_sel=0, pc_write=0, ifid_write=0, ifid_flush=0, pipe_hold=0 for that cycle; stay in RUN. The stall clears after exactly one cycle because the load advances.
REQ-024 RUN with branch_taken: ctrl_sel=0, ifid_flush=1, pc_write=1, ifid_write=1, pipe_hold=0; load flush counter with BR_EXTRA. Next state is FLUSH if BR_EXTRA>0, else RUN.
REQ-025 FLUSH: ctrl_sel=0, ifid_flush=1, pc_write=1, ifid_write=1, pipe_hold=0; decrement the flush counter; return to RUN when it reaches 0. LU is ignored in FLUSH.
REQ-026 branch_taken in FLUSH: reload the flush counter with BR_EXTRA and remain in FLUSH (go to RUN if BR_EXTRA=0).
REQ-027 mem_busy in any state: pipe_hold=1, pc_write=0, ifid_write=0, ifid_flush=0, ctrl_sel=1; next state MEMWAIT. Any pending flush count is discarded.
REQ-028 MEMWAIT: same outputs as REQ-027 while mem_busy=1. The first cycle with mem_busy=0 evaluates as RUN (REQ-022..024) and transitions accordingly.
REQ-029 branch_taken and LU are ignored while mem_busy=1.
REQ-030 Wait counter (8 bits) increments each cycle mem_busy=1, saturating at MAX_WAIT, and clears on the first cycle mem_busy=0.
REQ-031 mem_timeout sets on the edge where the wait counter reaches MAX_WAIT and stays set until reset.
REQ-032 bubble_count increments on each clock edge where ctrl_sel=0 and rst=0, and saturates at all-ones.

Reset
REQ-033 rst=1 immediately, without waiting for a clock edge, forces: state RUN, flush counter 0, wait counter 0, mem_timeout 0, bubble_count 0.
REQ-034 While rst=1: ctrl_sel=0, pc_write=0, ifid_write=0, ifid_flush=1, pipe_hold=0.
REQ-035 Reset asserted mid-FLUSH or mid-MEMWAIT aborts the operation. The first cycle after release behaves as RUN.

Verification
REQ-036 idex_memread=1, idex_rt=5, ifid_rs=5 for one cycle: ctrl_sel=0, pc_write=0, ifid_write=0 that cycle; next cycle all enables are 1; bubble_count=1.
REQ-037 idex_memread=1, idex_rt=0, ifid_rs=0: no stall (ctrl_sel=1, pc_write=1).
REQ-038 branch_taken pulse with BR_EXTRA=1: ctrl_sel=0 and ifid_flush=1 for 2 consecutive cycles, then RUN; bubble_count=2. A second branch_taken in cycle 2 gives 3 flush cycles total.
REQ-039 mem_busy=1 for 3 cycles with branch_taken and LU also asserted: pipe_hold=1, pc_write=0, ctrl_sel=1 for all 3 cycles; no flush; mem_timeout stays 0.
REQ-040 mem_busy held 255 cycles (MAX_WAIT=255): mem_timeout=1 after the 255th edge and stays 1 after mem_busy drops; only rst clears it.
REQ-041 rst asserted asynchronously mid-FLUSH: outputs take the REQ-034 values with no clock edge; bubble_count=0; after release, ctrl_sel=1, pc_write=1.
